debug_uart_tx: RTL
==================

Name: debug_uart_tx

Overview:
Downstream consumer of the debug-select mux output (32-bit `data` word also feeding the seven-segment display). Serialises the selected word as 8 uppercase ASCII hex digits followed by CR LF over an 8N1 UART line, so a host terminal can log PC / operands / writeback values while the core single-steps via the stall button. Sends on an explicit request or automatically whenever the word changes.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2
CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1

Ports:
clk      input   1   system clock, rising edge
rst      input   1   asynchronous, active-low reset
data     input   32  debug word from the select mux
send     input   1   single-cycle request to transmit the current `data`
auto_en  input   1   1 = transmit automatically when `data` differs from last word sent
tx       output  1   UART serial line, idle high
busy     output  1   1 while a frame is in progress
done     output  1   one-cycle pulse when the last stop bit of a frame completes

Behaviour:
- Reset (rst=0, async): tx=1, busy=0, done=0, state=IDLE, baud counter=0, bit index=0, char index=0, shadow word=0, last_sent=0. Reset mid-frame aborts immediately; no partial character is resumed after release.
- Trigger in IDLE: start when send=1, or when auto_en=1 and data != last_sent. On trigger, capture data into shadow and last_sent in the same edge; busy=1 from the next cycle.
- `send` or an auto condition while busy is ignored, not queued. Changes to `data` during a frame do not affect the frame. After the frame, auto mode compares against the captured word, so a value that changed mid-frame triggers a new frame once IDLE.
- Frame = 10 characters, char index 0..9: indices 0..7 = nibbles shadow[31:28] down to shadow[3:0]; index 8 = 0x0D; index 9 = 0x0A.
- Nibble-to-ASCII: n<=9 -> 0x30+n; n>=10 -> 0x41+(n-10), i.e. "A"-"F" uppercase.
- FSM states: IDLE -> START -> DATA -> STOP -> (char index<9 ? START with index+1 : IDLE).
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and is reset to 0 on every state entry. Characters are back-to-back with no idle gap.
- Latency: trigger sampled at edge T; tx falls at edge T+1 (start bit of char 0).
- Frame length: exactly 100*CLKS_PER_BIT cycles of busy=1.
- Frame completion: on the final stop-bit cycle, state returns to IDLE; busy=0 and done=1 for exactly one cycle from that edge. A new trigger is accepted in that same IDLE cycle, so back-to-back frames are separated by exactly one idle-high cycle.
- tx is registered (no combinational glitch). Output is held 1 in IDLE.
- send and auto trigger in the same cycle: a single frame is sent.

Test Plan:
- Reset: hold rst=0 with send=1 and random data -> tx=1, busy=0, done=0 throughout. Release -> stays idle until the first trigger.
- Basic frame (CLKS_PER_BIT=4): data=0x1234ABCF, pulse send -> UART monitor decodes "1234ABCF\r\n" (0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x46 0x0D 0x0A). busy high for exactly 400 cycles. done pulses once. tx falls one cycle after send.
- Busy collision: during the frame, change data to 0xDEADBEEF and pulse send twice -> the first frame is unchanged and no second frame occurs (auto_en=0).
- Auto mode: auto_en=1, data=0x00000000 after reset -> no frame. Set data=0x0000000A -> "0000000A\r\n" sent. Data held -> no further frames. Change to 0x80000000 mid-frame -> exactly one follow-up frame "80000000\r\n", beginning 1 cycle after done.
- Reset mid-frame: assert rst during char 3, data bit 5 -> tx=1 and busy=0 asynchronously (same timestep). After release with auto_en=0, the line stays idle.
- Boundary digits: data=0x09FA0F90 -> "09FA0F90\r\n", checking the 9/A and F/0 ASCII mapping edges.

Source files
------------

// File: rtl/debug_uart_tx.sv
// Serialises a 32-bit debug word as eight uppercase ASCII hex digits plus CR LF over 8N1 UART.
// Sends on an explicit request, or automatically when the word differs from the last one sent.
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        send,
    input  logic        auto_en,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [3:0]       char_idx, char_nxt;
    logic [31:0]      shadow, shadow_nxt;
    logic [31:0]      last_sent, last_nxt;
    logic             tx_nxt, done_nxt;
    logic             baud_last;
    logic             trigger;
    logic [3:0]       nibble;
    logic [7:0]       char_byte;

    // Handshake: send is a single-cycle request, only honoured in IDLE; requests
    // while busy are dropped, never queued. done pulses for one cycle per frame.
    assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign trigger   = send | (auto_en & (data != last_sent));
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        nibble = 4'h0;
        case (char_idx)
            4'd0:    nibble = shadow[31:28];
            4'd1:    nibble = shadow[27:24];
            4'd2:    nibble = shadow[23:20];
            4'd3:    nibble = shadow[19:16];
            4'd4:    nibble = shadow[15:12];
            4'd5:    nibble = shadow[11:8];
            4'd6:    nibble = shadow[7:4];
            4'd7:    nibble = shadow[3:0];
            default: nibble = 4'h0;
        endcase
    end

    // 0x37 + n maps 10..15 onto 'A'..'F'
    always_comb begin
        char_byte = 8'h00;
        if (char_idx == 4'd8)
            char_byte = 8'h0D;
        else if (char_idx == 4'd9)
            char_byte = 8'h0A;
        else if (nibble <= 4'd9)
            char_byte = 8'h30 + {4'h0, nibble};
        else
            char_byte = 8'h37 + {4'h0, nibble};
    end

    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt + CNT_W'(1);
        bit_nxt    = bit_idx;
        char_nxt   = char_idx;
        shadow_nxt = shadow;
        last_nxt   = last_sent;
        tx_nxt     = 1'b1;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (trigger) begin
                    state_nxt  = START;
                    shadow_nxt = data;
                    last_nxt   = data;
                    char_nxt   = 4'd0;
                    bit_nxt    = 3'd0;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_last) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                tx_nxt = char_byte[bit_idx];
                if (baud_last) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7)
                        state_nxt = STOP;
                    else
                        bit_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_last) begin
                    baud_nxt = '0;
                    if (char_idx == 4'd9) begin
                        state_nxt = IDLE;
                        char_nxt  = 4'd0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = START;
                        char_nxt  = char_idx + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            char_idx  <= 4'd0;
            shadow    <= 32'h0;
            last_sent <= 32'h0;
            tx        <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            char_idx  <= char_nxt;
            shadow    <= shadow_nxt;
            last_sent <= last_nxt;
            tx        <= tx_nxt;
            done      <= done_nxt;
        end
    end

endmodule
